// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: two-entry ready/valid buffer (head + skid) carrying
// LANES write-back lanes per beat, with lane qualification and head forwarding.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ADDR_W-1:0]  dest_addr,
  input  logic [LANES-1:0]         write_or_not,
  input  logic [LANES*DATA_W-1:0]  wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ADDR_W-1:0]  dest_addr_output,
  output logic [LANES-1:0]         write_or_not_output,
  output logic [LANES*DATA_W-1:0]  wdata_output,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LANES*ADDR_W-1:0] head_addr, skid_addr;
  logic [LANES-1:0]        head_wen,  skid_wen;
  logic [LANES*DATA_W-1:0] head_data, skid_data;

  logic [LANES-1:0] in_wen_q;
  logic accept, pop;
  logic load_head_in, load_head_skid, load_skid, clr_head_wen;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Register 0 never written; on same-address conflicts the highest lane wins.
  always_comb begin
    in_wen_q = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      in_wen_q[i] = write_or_not[i] && (dest_addr[i*ADDR_W +: ADDR_W] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (write_or_not[j] &&
            (dest_addr[j*ADDR_W +: ADDR_W] == dest_addr[i*ADDR_W +: ADDR_W]))
          in_wen_q[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    clr_head_wen   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_head_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          clr_head_wen = 1'b1;
          state_d      = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any same-cycle capture; a same-cycle pop is still consumed.
    if (flush) begin
      state_d        = EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      clr_head_wen   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_addr <= '0;
      head_wen  <= '0;
      head_data <= '0;
    end else if (load_head_in) begin
      head_addr <= dest_addr;
      head_wen  <= in_wen_q;
      head_data <= wdata;
    end else if (load_head_skid) begin
      head_addr <= skid_addr;
      head_wen  <= skid_wen;
      head_data <= skid_data;
    end else if (clr_head_wen) begin
      head_wen  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_addr <= '0;
      skid_wen  <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_addr <= dest_addr;
      skid_wen  <= in_wen_q;
      skid_data <= wdata;
    end else if (flush) begin
      skid_wen  <= '0;
    end
  end

  assign dest_addr_output    = head_addr;
  assign write_or_not_output = head_wen;
  assign wdata_output        = head_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (out_valid && head_wen[i] && (fwd_addr != '0) &&
          (head_addr[i*ADDR_W +: ADDR_W] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = head_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed plus randomised checks of mem_wb_pipe with two lanes, against
// hand-computed values and a queue reference model.
module tb_mem_wb_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LANES  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ADDR_W-1:0] dest_addr;
  logic [LANES-1:0]        write_or_not;
  logic [LANES*DATA_W-1:0] wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ADDR_W-1:0] dest_addr_output;
  logic [LANES-1:0]        write_or_not_output;
  logic [LANES*DATA_W-1:0] wdata_output;
  logic [ADDR_W-1:0]       fwd_addr;
  logic                    fwd_hit;
  logic [DATA_W-1:0]       fwd_data;

  int errors = 0;
  int checks = 0;

  mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .dest_addr           (dest_addr),
    .write_or_not        (write_or_not),
    .wdata               (wdata),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .dest_addr_output    (dest_addr_output),
    .write_or_not_output (write_or_not_output),
    .wdata_output        (wdata_output),
    .fwd_addr            (fwd_addr),
    .fwd_hit             (fwd_hit),
    .fwd_data            (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane1 fields first, then lane0
  task automatic beat(input logic v,
                      input logic [4:0] a1, input logic w1, input logic [31:0] d1,
                      input logic [4:0] a0, input logic w0, input logic [31:0] d0);
    in_valid     = v;
    dest_addr    = {a1, a0};
    write_or_not = {w1, w0};
    wdata        = {d1, d0};
  endtask

  typedef struct packed {
    logic [9:0]  a;
    logic [1:0]  w;
    logic [63:0] d;
  } beat_t;

  beat_t q[$];

  initial begin
    logic  acc, pp, fl;
    beat_t b;
    logic [4:0] a0, a1;

    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; fwd_addr = '0;
    beat(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wen", write_or_not_output, 2'b00);
    chk("rst_addr", dest_addr_output, 10'd0);
    chk("rst_data", wdata_output, 64'd0);
    chk("rst_fwd", {fwd_hit, fwd_data}, 33'd0);

    // streaming, out_ready high
    out_ready = 1'b1;
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'h11);
    tick();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_head", {dest_addr_output, write_or_not_output, wdata_output},
        {10'd3, 2'b01, 64'h11});
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h22);
    tick();
    chk("s2_head", {dest_addr_output, write_or_not_output, wdata_output},
        {10'd4, 2'b01, 64'h22});
    chk("s2_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("s3_empty", {out_valid, write_or_not_output}, 3'b000);
    chk("s3_addr_hold", dest_addr_output, 10'd4);

    // asynchronous reset while FULL
    out_ready = 1'b0;
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'h11);
    tick();
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h22);
    tick();
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_outs", {out_valid, in_ready, write_or_not_output, dest_addr_output, wdata_output},
        {1'b0, 1'b1, 2'b00, 10'd0, 64'd0});
    chk("arst_fwd", {fwd_hit, fwd_data}, 33'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("arst_dropped", out_valid, 1'b0);

    // backpressure into skid
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd1, 1'b1, 32'hA);
    tick();
    chk("bp_A_head", {out_valid, in_ready, wdata_output}, {1'b1, 1'b1, 64'hA});
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd2, 1'b1, 32'hB);
    tick();
    chk("bp_full", {in_ready, wdata_output}, {1'b0, 64'hA});
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'hC);
    tick();
    chk("bp_hold", {in_ready, wdata_output, dest_addr_output}, {1'b0, 64'hA, 10'd1});
    out_ready = 1'b1;
    tick();
    chk("bp_B_head", {in_ready, wdata_output, dest_addr_output}, {1'b1, 64'hB, 10'd2});
    tick();
    chk("bp_C_head", {out_valid, wdata_output, dest_addr_output}, {1'b1, 64'hC, 10'd6});
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // flush while FULL with a beat offered
    out_ready = 1'b0;
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd1, 1'b1, 32'h1);
    tick();
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd2, 1'b1, 32'h2);
    tick();
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'hC);
    flush = 1'b1;
    tick();
    chk("fl_full", {out_valid, write_or_not_output, in_ready}, {1'b0, 2'b00, 1'b1});
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("fl_no_C", out_valid, 1'b0);
    // flush in ONE discards a same-cycle accepted beat
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd1, 1'b1, 32'h1);
    tick();
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'hC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_one", {out_valid, write_or_not_output, in_ready}, {1'b0, 2'b00, 1'b1});
    tick();
    chk("fl_one_after", out_valid, 1'b0);

    // register 0 suppression and lane conflict
    beat(1'b1, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h55);
    tick();
    chk("r0_wen", {out_valid, write_or_not_output}, {1'b1, 2'b00});
    fwd_addr = 5'd0;
    #1;
    chk("r0_fwd_miss", fwd_hit, 1'b0);
    out_ready = 1'b1;
    beat(1'b1, 5'd7, 1'b1, 32'h2, 5'd7, 1'b1, 32'h1);
    tick();
    chk("conf_wen", write_or_not_output, 2'b10);
    fwd_addr = 5'd7;
    #1;
    chk("conf_fwd", {fwd_hit, fwd_data}, {1'b1, 32'h2});
    fwd_addr = 5'd3;
    #1;
    chk("conf_fwd_miss", {fwd_hit, fwd_data}, 33'd0);
    // distinct addresses keep both lanes
    beat(1'b1, 5'd9, 1'b1, 32'h99, 5'd8, 1'b1, 32'h88);
    tick();
    chk("two_wen", write_or_not_output, 2'b11);
    fwd_addr = 5'd8;
    #1;
    chk("two_fwd_l0", {fwd_hit, fwd_data}, {1'b1, 32'h88});
    in_valid = 1'b0;
    tick();
    fwd_addr = 5'd5;
    #1;
    chk("empty_fwd5", {fwd_hit, fwd_data}, 33'd0);
    fwd_addr = 5'd9;
    #1;
    chk("empty_fwd9", {fwd_hit, fwd_data}, 33'd0);

    // randomised traffic against a queue model
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      a0 = 5'($urandom_range(0, 3));
      a1 = 5'($urandom_range(0, 3));
      beat(1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), $urandom,
           a0, 1'($urandom_range(0, 1)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      fwd_addr  = 5'($urandom_range(0, 3));
      #1;
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      chk("rnd_out_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_head", {dest_addr_output, write_or_not_output, wdata_output}, q[0]);
      end else begin
        chk("rnd_empty_wen", write_or_not_output, 2'b00);
      end
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      fl  = flush;
      b.a = dest_addr;
      b.d = wdata;
      b.w[1] = write_or_not[1] && (a1 != 5'd0);
      b.w[0] = write_or_not[0] && (a0 != 5'd0) && !(write_or_not[1] && (a1 == a0));
      tick();
      if (fl) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
